// File: rtl/m_wbregbank.sv
// m_wbregbank: Wishbone classic slave register bank with byte-lane writes,
// programmable wait states and an optional doorbell interrupt on the last register.
module m_wbregbank #(
  parameter int          NREGS      = 4,
  parameter int          WAITSTATES = 0,
  parameter logic [31:0] RESETVAL   = 32'h0,
  parameter int          DOORBELL   = 1,
  localparam int         AW         = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          CLK_I,
  input  logic          RST_NI,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [3:0]    SEL_I,
  input  logic [31:0]   DAT_I,
  output logic          ACK_O,
  output logic [31:0]   DAT_O,
  output logic          irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q, irq_d;
  logic [31:0]   regs_q [NREGS];
  logic [31:0]   regs_d [NREGS];
  logic [AW-1:0] idx;

  // With a single register the address bus carries no information.
  assign idx = (NREGS == 1) ? '0 : ADR_I;

  // Next-state logic: handshake sequencing, read capture, lane writes and doorbell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    irq_d   = irq_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (STB_I) begin
          if (WAITSTATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAITSTATES - 1);
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            dat_d   = regs_q[idx];
          end
        end
      end
      S_WAIT: begin
        if (!STB_I) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 3'd0) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = regs_q[idx];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (STB_I) begin
          if (WE_I) begin
            for (int k = 0; k < 4; k++) begin
              if (SEL_I[k]) regs_d[idx][8*k +: 8] = DAT_I[8*k +: 8];
            end
            if ((DOORBELL != 0) && (idx == LAST) && (SEL_I != 4'h0)) irq_d = 1'b1;
          end else if ((DOORBELL != 0) && (idx == LAST)) begin
            irq_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESETVAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      regs_q  <= regs_d;
    end
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_m_wbregbank.sv
// tb_m_wbregbank: directed bench for the Wishbone register bank, one instance
// with no wait states and one with three.
module tb_m_wbregbank;

  localparam logic [31:0] RV = 32'hA5A50F0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb0, stb3, we;
  logic [1:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        ack0, ack3, irq0, irq3;
  logic [31:0] dat0, dat3;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] rdata;
  int          lat;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  m_wbregbank #(.NREGS(4), .WAITSTATES(0), .RESETVAL(RV), .DOORBELL(1)) dut0 (
    .CLK_I(clk), .RST_NI(rst_n), .STB_I(stb0), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(wdat), .ACK_O(ack0), .DAT_O(dat0), .irq_o(irq0)
  );

  m_wbregbank #(.NREGS(4), .WAITSTATES(3), .RESETVAL(RV), .DOORBELL(1)) dut3 (
    .CLK_I(clk), .RST_NI(rst_n), .STB_I(stb3), .WE_I(we), .ADR_I(adr),
    .SEL_I(sel), .DAT_I(wdat), .ACK_O(ack3), .DAT_O(dat3), .irq_o(irq3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    else passes++;
  endtask

  // One full bus access; returns read data and the cycle count from strobe to ACK.
  task automatic applyStimulus(input bit use3, input bit w, input logic [1:0] a,
                               input logic [3:0] s, input logic [31:0] d,
                               output logic [31:0] rd, output int l);
    bit got;
    we = w; adr = a; sel = s; wdat = d;
    l = 0; rd = '0; got = 1'b0;
    if (use3) stb3 = 1'b1; else stb0 = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      l++;
      if (use3 ? ack3 : ack0) begin
        got = 1'b1;
        rd  = use3 ? dat3 : dat0;
      end
    end
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
    else cyc();
    stb0 = 1'b0;
    stb3 = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stb0 = 1'b1; stb3 = 1'b1; we = 1'b0; adr = '0; sel = '0; wdat = '0;

    // Reset held with strobe asserted
    cyc(); cyc(); cyc();
    checkOutput("rst_ack0", {31'b0, ack0}, 32'd0);
    checkOutput("rst_dat0", dat0, 32'd0);
    checkOutput("rst_irq0", {31'b0, irq0}, 32'd0);
    checkOutput("rst_ack3", {31'b0, ack3}, 32'd0);
    stb0 = 1'b0; stb3 = 1'b0;
    rst_n = 1'b1;
    cyc();
    applyStimulus(0, 0, 2'd2, 4'h0, 32'h0, rdata, lat);
    checkOutput("rst_reg2", rdata, RV);

    // Zero wait states: full-word write then read back
    applyStimulus(0, 1, 2'd1, 4'hF, 32'hDEADBEEF, rdata, lat);
    checkOutput("ws0_wr_lat", 32'(lat), 32'd1);
    applyStimulus(0, 0, 2'd1, 4'h0, 32'h0, rdata, lat);
    checkOutput("ws0_rd_lat", 32'(lat), 32'd1);
    checkOutput("ws0_rd_data", rdata, 32'hDEADBEEF);
    checkOutput("ws0_dat_idle", dat0, 32'd0);

    // Byte lanes, plus an empty-select write that must change nothing
    applyStimulus(0, 1, 2'd0, 4'hF, 32'h11223344, rdata, lat);
    applyStimulus(0, 1, 2'd0, 4'b0101, 32'hAABBCCDD, rdata, lat);
    applyStimulus(0, 0, 2'd0, 4'h0, 32'h0, rdata, lat);
    checkOutput("lanes_0101", rdata, 32'h11BB33DD);
    applyStimulus(0, 1, 2'd0, 4'h0, 32'hFFFFFFFF, rdata, lat);
    checkOutput("sel0_lat", 32'(lat), 32'd1);
    applyStimulus(0, 0, 2'd0, 4'h0, 32'h0, rdata, lat);
    checkOutput("sel0_unchanged", rdata, 32'h11BB33DD);

    // Three wait states, then an aborted write
    applyStimulus(1, 1, 2'd2, 4'hF, 32'h12345678, rdata, lat);
    checkOutput("ws3_wr_lat", 32'(lat), 32'd4);
    applyStimulus(1, 0, 2'd2, 4'h0, 32'h0, rdata, lat);
    checkOutput("ws3_rd_lat", 32'(lat), 32'd4);
    checkOutput("ws3_rd_data", rdata, 32'h12345678);
    we = 1'b1; adr = 2'd2; sel = 4'hF; wdat = 32'hFFFFFFFF; stb3 = 1'b1;
    cyc();
    checkOutput("abort_ack_c1", {31'b0, ack3}, 32'd0);
    cyc();
    checkOutput("abort_ack_c2", {31'b0, ack3}, 32'd0);
    stb3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checkOutput("abort_no_ack", {31'b0, ack3}, 32'd0);
    end
    applyStimulus(1, 0, 2'd2, 4'h0, 32'h0, rdata, lat);
    checkOutput("abort_reg_kept", rdata, 32'h12345678);

    // Strobe held for six cycles: ACK on odd cycles only
    we = 1'b0; adr = 2'd1; sel = 4'h0; stb0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checkOutput($sformatf("held_ack_c%0d", i), {31'b0, ack0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 1) checkOutput("held_dat_c1", dat0, 32'hDEADBEEF);
    end
    stb0 = 1'b0;
    cyc();

    // Doorbell on the last register
    checkOutput("db_irq_init", {31'b0, irq0}, 32'd0);
    applyStimulus(0, 1, 2'd3, 4'h1, 32'h1, rdata, lat);
    checkOutput("db_irq_set", {31'b0, irq0}, 32'd1);
    applyStimulus(0, 0, 2'd0, 4'h0, 32'h0, rdata, lat);
    checkOutput("db_irq_keep", {31'b0, irq0}, 32'd1);
    applyStimulus(0, 0, 2'd3, 4'h0, 32'h0, rdata, lat);
    checkOutput("db_rd_data", rdata, 32'hA5A50F01);
    checkOutput("db_irq_clr", {31'b0, irq0}, 32'd0);
    applyStimulus(0, 1, 2'd3, 4'h0, 32'h0, rdata, lat);
    checkOutput("db_sel0_no_irq", {31'b0, irq0}, 32'd0);
    applyStimulus(0, 1, 2'd3, 4'h2, 32'h00000200, rdata, lat);
    applyStimulus(1, 1, 2'd3, 4'h1, 32'h1, rdata, lat);
    checkOutput("db3_irq_set", {31'b0, irq3}, 32'd1);
    checkOutput("db0_irq_set2", {31'b0, irq0}, 32'd1);

    // Reset while dut3 sits in its wait states
    we = 1'b1; adr = 2'd2; sel = 4'hF; wdat = 32'h0BADF00D; stb3 = 1'b1;
    cyc();
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_irq3", {31'b0, irq3}, 32'd0);
    checkOutput("rstw_irq0", {31'b0, irq0}, 32'd0);
    checkOutput("rstw_ack3", {31'b0, ack3}, 32'd0);
    stb3 = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    applyStimulus(1, 0, 2'd2, 4'h0, 32'h0, rdata, lat);
    checkOutput("rstw_reg2", rdata, RV);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
